// File: rtl/loader_pkg.sv
// Shared types and default widths for the program loader and its run timer.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        REL,
        REQ,
        RUN,
        FIN,
        ERR
    } ldr_state_t;

    localparam int D_DEF  = 12;
    localparam int W_DEF  = 9;
    localparam int CW_DEF = 16;

endpackage

// File: rtl/run_timer.sv
// Saturating run-cycle counter. With PROG_LOADER_WATCHDOG_EN defined it also
// flags the counting cycle whose increment brings the count up to MAX_CYC.
module run_timer
    import loader_pkg::*;
#(
    parameter int CW = CW_DEF
`ifdef PROG_LOADER_WATCHDOG_EN
    ,
    parameter logic [CW-1:0] MAX_CYC = '1
`endif
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          enable,
    output logic [CW-1:0] count
`ifdef PROG_LOADER_WATCHDOG_EN
    ,
    output logic          expired
`endif
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

`ifdef PROG_LOADER_WATCHDOG_EN
    // Asserted one cycle early so the FSM leaves RUN on the same edge that
    // the count lands on MAX_CYC.
    assign expired = enable && (count == CW'(MAX_CYC - 1'b1));
`endif

endmodule

// File: rtl/prog_loader.sv
// Program loader and run sequencer: streams code into instruction memory with
// the core held in reset, then releases it, pulses req and times the run.
// Optional watchdog on the run phase: PROG_LOADER_WATCHDOG_EN.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | core held in reset, waiting for start
// LOAD  | accepting words, writing instruction memory
// REL   | core released from reset; last word is being written
// REQ   | one-cycle start request to the core, cycle count cleared
// RUN   | counting cycles until core_done (or watchdog expiry)
// FIN   | one-cycle finished pulse, core back into reset
// ERR   | overflow or timeout; core held in reset until next start
module prog_loader
    import loader_pkg::*;
#(
    parameter int D  = D_DEF,
    parameter int W  = W_DEF,
    parameter int CW = CW_DEF
`ifdef PROG_LOADER_WATCHDOG_EN
    ,
    parameter logic [CW-1:0] MAX_CYC = '1
`endif
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          ld_valid,
    input  logic [W-1:0]  ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    output logic          im_wr_en,
    output logic [D-1:0]  im_addr,
    output logic [W-1:0]  im_dat,
    output logic          core_rst,
    output logic          core_req,
    input  logic          core_done,
    output logic          busy,
    output logic          finished,
    output logic          timeout,
    output logic          overflow,
    output logic [CW-1:0] cycles
);

    ldr_state_t   state;
    ldr_state_t   state_nxt;
    logic [D-1:0] addr;
    logic         xfer;
    logic         addr_top;
    logic         start_ok;
    logic         cyc_clear;
    logic         cyc_en;
    logic         wd_hit;

    assign ld_ready = (state == LOAD);
    assign xfer     = ld_valid && ld_ready;
    assign addr_top = (addr == '1);
    assign start_ok = start && ((state == IDLE) || (state == ERR));

    run_timer #(
        .CW      (CW)
`ifdef PROG_LOADER_WATCHDOG_EN
        ,
        .MAX_CYC (MAX_CYC)
`endif
    ) u_run_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (cyc_clear),
        .enable  (cyc_en),
        .count   (cycles)
`ifdef PROG_LOADER_WATCHDOG_EN
        ,
        .expired (wd_hit)
`endif
    );

`ifndef PROG_LOADER_WATCHDOG_EN
    assign wd_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        core_rst  = 1'b1;
        core_req  = 1'b0;
        busy      = 1'b0;
        finished  = 1'b0;
        cyc_clear = 1'b0;
        cyc_en    = 1'b0;
        unique case (state)
            IDLE, ERR: begin
                if (start) begin
                    state_nxt = LOAD;
                    cyc_clear = 1'b1;
                end
            end
            LOAD: begin
                busy = 1'b1;
                if (xfer) begin
                    if (ld_last) begin
                        state_nxt = REL;
                    end else if (addr_top) begin
                        state_nxt = ERR;
                    end
                end
            end
            REL: begin
                busy      = 1'b1;
                core_rst  = 1'b0;
                state_nxt = REQ;
            end
            REQ: begin
                busy      = 1'b1;
                core_rst  = 1'b0;
                core_req  = 1'b1;
                cyc_clear = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                busy     = 1'b1;
                core_rst = 1'b0;
                cyc_en   = 1'b1;
                // done takes priority over a simultaneous watchdog hit
                if (core_done) begin
                    state_nxt = FIN;
                end else if (wd_hit) begin
                    state_nxt = ERR;
                end
            end
            FIN: begin
                finished  = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            addr     <= '0;
            im_wr_en <= 1'b0;
            im_addr  <= '0;
            im_dat   <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            im_wr_en <= xfer;
            if (xfer) begin
                im_addr <= addr;
                im_dat  <= ld_data;
                addr    <= addr + 1'b1;
            end
            if (start_ok) begin
                addr     <= '0;
                overflow <= 1'b0;
            end else if (xfer && addr_top && !ld_last) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef PROG_LOADER_WATCHDOG_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            timeout <= 1'b0;
        end else if (start_ok) begin
            timeout <= 1'b0;
        end else if ((state == RUN) && !core_done && wd_hit) begin
            timeout <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader (D=3, CW=8; MAX_CYC=20 when the
// watchdog is compiled in).
module tb_prog_loader;

    localparam int D  = 3;
    localparam int W  = 9;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          ld_valid = 1'b0;
    logic [W-1:0]  ld_data = '0;
    logic          ld_last = 1'b0;
    logic          ld_ready;
    logic          im_wr_en;
    logic [D-1:0]  im_addr;
    logic [W-1:0]  im_dat;
    logic          core_rst;
    logic          core_req;
    logic          core_done = 1'b0;
    logic          busy;
    logic          finished;
    logic          timeout;
    logic          overflow;
    logic [CW-1:0] cycles;

    int n_vec  = 0;
    int n_miss = 0;
    int wr_cnt  = 0;
    int req_cnt = 0;
    int fin_cnt = 0;

    prog_loader #(
        .D  (D),
        .W  (W),
        .CW (CW)
`ifdef PROG_LOADER_WATCHDOG_EN
        ,
        .MAX_CYC (8'd20)
`endif
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .ld_ready  (ld_ready),
        .im_wr_en  (im_wr_en),
        .im_addr   (im_addr),
        .im_dat    (im_dat),
        .core_rst  (core_rst),
        .core_req  (core_req),
        .core_done (core_done),
        .busy      (busy),
        .finished  (finished),
        .timeout   (timeout),
        .overflow  (overflow),
        .cycles    (cycles)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset) begin
            if (im_wr_en) wr_cnt++;
            if (core_req) req_cnt++;
            if (finished) fin_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_wr_en"}, im_wr_en, 0);
        chk({tag, "_addr"}, im_addr, 0);
        chk({tag, "_dat"}, im_dat, 0);
        chk({tag, "_core_rst"}, core_rst, 1);
        chk({tag, "_core_req"}, core_req, 0);
        chk({tag, "_ld_ready"}, ld_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_finished"}, finished, 0);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_cycles"}, cycles, 0);
    endtask

    // Back-to-back stream of n words from base; each write shows up one cycle
    // after its handshake.
    task automatic load_prog(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            ld_valid = 1'b1;
            ld_data  = W'(base + i);
            ld_last  = (i == n - 1);
            tick();
            chk("wr_en", im_wr_en, 1);
            chk("wr_addr", im_addr, i);
            chk("wr_dat", im_dat, base + i);
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    // Entered in the REL cycle. done_at = RUN cycle (1-based) in which done is high.
    task automatic run_core(input int done_at, input bit early, input int exp_cyc);
        chk("rel_core_rst", core_rst, 0);
        chk("rel_core_req", core_req, 0);
        core_done = early;
        tick();
        chk("req_pulse", core_req, 1);
        chk("req_core_rst", core_rst, 0);
        tick();
        core_done = 1'b0;
        chk("req_width", core_req, 0);
        repeat (done_at - 1) tick();
        chk("run_busy", busy, 1);
        chk("run_no_fin", finished, 0);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk("fin_pulse", finished, 1);
        chk("fin_cycles", cycles, exp_cyc);
        chk("fin_core_rst", core_rst, 1);
        tick();
        chk("fin_width", finished, 0);
        chk("cycles_hold", cycles, exp_cyc);
    endtask

    initial begin
        int w0, q0, f0, exp_a;
        bit pat[5];

        repeat (3) tick();
        chk_reset_vals("por");
        reset = 1'b1;
        tick();
        chk("idle_ld_ready", ld_ready, 0);

        // normal run: 4 words, done 10 cycles after req
        w0 = wr_cnt; q0 = req_cnt; f0 = fin_cnt;
        do_start();
        chk("load_ld_ready", ld_ready, 1);
        chk("load_busy", busy, 1);
        chk("load_core_rst", core_rst, 1);
        load_prog(4, 'h1A0);
        run_core(10, 1'b0, 10);
        chk("norm_writes", wr_cnt - w0, 4);
        chk("norm_reqs", req_cnt - q0, 1);
        chk("norm_fins", fin_cnt - f0, 1);

        // backpressure gaps, with done held high through REL/REQ
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        w0 = wr_cnt;
        exp_a = 0;
        do_start();
        chk("bp_cycles_clr", cycles, 0);
        for (int i = 0; i < 5; i++) begin
            ld_valid = pat[i];
            ld_data  = W'('h50 + i);
            ld_last  = (i == 4);
            tick();
            chk("bp_wr_en", im_wr_en, pat[i]);
            if (pat[i]) begin
                chk("bp_addr", im_addr, exp_a);
                chk("bp_dat", im_dat, 'h50 + i);
                exp_a++;
            end
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        run_core(3, 1'b1, 3);
        chk("bp_writes", wr_cnt - w0, 3);

        // overflow: 9 words into an 8-word space, no last
        w0 = wr_cnt; q0 = req_cnt;
        do_start();
        for (int i = 0; i < 9; i++) begin
            ld_valid = 1'b1;
            ld_data  = W'('h100 + i);
            tick();
            if (i == 7) chk("ovf_set", overflow, 1);
        end
        ld_valid = 1'b0;
        tick();
        chk("ovf_writes", wr_cnt - w0, 8);
        chk("ovf_sticky", overflow, 1);
        chk("ovf_last_addr", im_addr, 7);
        chk("ovf_last_dat", im_dat, 'h107);
        chk("err_busy", busy, 0);
        chk("err_ld_ready", ld_ready, 0);
        chk("err_core_rst", core_rst, 1);
        chk("ovf_no_req", req_cnt - q0, 0);

        // restart from ERR; a last word at the top address is legal
        do_start();
        chk("ovf_clr", overflow, 0);
        chk("err_restart", ld_ready, 1);
        load_prog(8, 'h0C0);
        chk("top_last_ok", overflow, 0);
        run_core(2, 1'b0, 2);

`ifdef PROG_LOADER_WATCHDOG_EN
        // done coinciding with expiry wins
        do_start();
        load_prog(1, 'h1FF);
        run_core(20, 1'b0, 20);
        chk("wd_done_wins", timeout, 0);
        // no done: timeout after 20 RUN cycles
        do_start();
        load_prog(1, 'h0AA);
        tick();
        tick();
        repeat (19) tick();
        chk("wd_run20_busy", busy, 1);
        chk("wd_run20_to", timeout, 0);
        tick();
        chk("wd_timeout", timeout, 1);
        chk("wd_core_rst", core_rst, 1);
        chk("wd_busy", busy, 0);
        chk("wd_cycles", cycles, 20);
        do_start();
        chk("wd_clr", timeout, 0);
        chk("wd_cyc_clr", cycles, 0);
        load_prog(1, 'h0AB);
        run_core(4, 1'b0, 4);
`else
        // done in the same cycle the counter saturates, then done well past it
        do_start();
        load_prog(1, 'h1FF);
        run_core(255, 1'b0, 255);
        do_start();
        load_prog(1, 'h0AA);
        run_core(300, 1'b0, 255);
`endif

        // reset held 3 cycles mid-LOAD
        do_start();
        ld_valid = 1'b1;
        ld_data  = W'('h033);
        tick();
        tick();
        reset = 1'b0;
        repeat (3) tick();
        chk_reset_vals("rst_load");
        ld_valid = 1'b0;
        reset = 1'b1;
        tick();
        chk("rst_idle", ld_ready, 0);

        // reset mid-RUN clears the count and re-asserts core reset
        do_start();
        load_prog(1, 'h011);
        repeat (6) tick();
        chk("mid_run_cycles", cycles, 4);
        reset = 1'b0;
        tick();
        chk_reset_vals("rst_run");
        reset = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
